// File: rtl/dm_obi_arbiter.sv
// Round-robin arbiter sharing one downstream OBI slave port between NrPorts masters.
// Responses return in order to the originating port with its aid mirrored on rid_o.
module dm_obi_arbiter #(
  parameter int unsigned NrPorts        = 2,
  parameter int unsigned BusWidth       = 32,
  parameter int unsigned IdWidth        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NrPorts-1:0]              req_i,
  output logic [NrPorts-1:0]              gnt_o,
  input  logic [NrPorts-1:0]              we_i,
  input  logic [NrPorts*BusWidth-1:0]     addr_i,
  input  logic [NrPorts*BusWidth/8-1:0]   be_i,
  input  logic [NrPorts*BusWidth-1:0]     wdata_i,
  input  logic [NrPorts*IdWidth-1:0]      aid_i,
  output logic [NrPorts-1:0]              rvalid_o,
  output logic [BusWidth-1:0]             rdata_o,
  output logic [IdWidth-1:0]              rid_o,
  output logic                            m_req_o,
  input  logic                            m_gnt_i,
  output logic                            m_we_o,
  output logic [BusWidth-1:0]             m_addr_o,
  output logic [BusWidth/8-1:0]           m_be_o,
  output logic [BusWidth-1:0]             m_wdata_o,
  input  logic                            m_rvalid_i,
  input  logic [BusWidth-1:0]             m_rdata_i
);

  localparam int unsigned IdxW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeW  = BusWidth / 8;

  typedef struct packed {
    logic [IdxW-1:0]    idx;
    logic [IdWidth-1:0] aid;
  } entry_t;

  logic [BusWidth-1:0] addr_a  [NrPorts];
  logic [BusWidth-1:0] wdata_a [NrPorts];
  logic [BeW-1:0]      be_a    [NrPorts];
  logic [IdWidth-1:0]  aid_a   [NrPorts];

  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    assign addr_a[p]  = addr_i[p*BusWidth +: BusWidth];
    assign wdata_a[p] = wdata_i[p*BusWidth +: BusWidth];
    assign be_a[p]    = be_i[p*BeW +: BeW];
    assign aid_a[p]   = aid_i[p*IdWidth +: IdWidth];
  end

  logic [IdxW-1:0] rr_q, rr_d;
  logic            lock_vld_q, lock_vld_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  entry_t          fifo_q [MaxOutstanding];

  logic            full, empty, hs, pop, found;
  logic [IdxW-1:0] winner;
  int unsigned     cand;
  entry_t          head;

  function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A locked port keeps the downstream address phase stable until it is accepted.
  always_comb begin
    winner = lock_idx_q;
    found  = 1'b0;
    cand   = 0;
    if (!lock_vld_q) begin
      winner = rr_q;
      for (int unsigned i = 0; i < NrPorts; i++) begin
        cand = 32'(rr_q) + i;
        if (cand >= NrPorts) cand = cand - NrPorts;
        if (!found && req_i[IdxW'(cand)]) begin
          winner = IdxW'(cand);
          found  = 1'b1;
        end
      end
    end
  end

  assign full    = (count_q == CntW'(MaxOutstanding));
  assign empty   = (count_q == '0);
  assign m_req_o = rst_ni & (|req_i) & ~full;
  assign hs      = m_req_o & m_gnt_i;
  assign pop     = m_rvalid_i & ~empty;
  assign head    = fifo_q[rd_q];
  assign rdata_o = m_rdata_i;

  always_comb begin
    gnt_o     = '0;
    rvalid_o  = '0;
    rid_o     = '0;
    m_we_o    = 1'b0;
    m_addr_o  = '0;
    m_be_o    = '0;
    m_wdata_o = '0;
    if (hs) gnt_o[winner] = 1'b1;
    if (m_req_o) begin
      m_we_o    = we_i[winner];
      m_addr_o  = addr_a[winner];
      m_be_o    = be_a[winner];
      m_wdata_o = wdata_a[winner];
    end
    if (pop) begin
      rvalid_o[head.idx] = 1'b1;
      rid_o              = head.aid;
    end
  end

  always_comb begin
    rr_d       = rr_q;
    lock_vld_d = lock_vld_q;
    lock_idx_d = lock_idx_q;
    count_d    = count_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    if (hs) begin
      rr_d       = (winner == IdxW'(NrPorts - 1)) ? '0 : winner + IdxW'(1);
      lock_vld_d = 1'b0;
      wr_d       = inc_ptr(wr_q);
    end else if (m_req_o) begin
      lock_vld_d = 1'b1;
      lock_idx_d = winner;
    end
    if (pop) rd_d = inc_ptr(rd_q);
    if (hs && !pop)      count_d = count_q + CntW'(1);
    else if (!hs && pop) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (hs) fifo_q[wr_q] <= '{idx: winner, aid: aid_a[winner]};
  end

`ifndef SYNTHESIS
  a_rvalid_with_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    m_rvalid_i |-> !empty);
  a_req_held_until_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_vld_q |-> req_i[lock_idx_q]);
`endif

endmodule

// File: tb/tb_dm_obi_arbiter.sv
// Bench for dm_obi_arbiter: directed vector table, reset sequence, randomized run vs queue model.
module tb_dm_obi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, gnt, we, rvalid, aid;
  logic [63:0] addr, wdata;
  logic [7:0]  be;
  logic [31:0] rdata, m_addr, m_wdata, m_rdata;
  logic [0:0]  rid;
  logic        m_req, m_gnt, m_we, m_rvalid;
  logic [3:0]  m_be;

  always #5 clk = ~clk;

  dm_obi_arbiter #(
    .NrPorts(2), .BusWidth(32), .IdWidth(1), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .aid_i(aid), .rvalid_o(rvalid), .rdata_o(rdata), .rid_o(rid),
    .m_req_o(m_req), .m_gnt_i(m_gnt), .m_we_o(m_we), .m_addr_o(m_addr),
    .m_be_o(m_be), .m_wdata_o(m_wdata), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  aid;
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic [1:0]  e_gnt;
    logic        e_mreq;
    logic [31:0] e_addr;
    logic [1:0]  e_rv;
    logic        e_rid;
  } vec_t;

  vec_t tbl [23];

  typedef struct { int idx; int aid; } ent_t;
  ent_t        q[$];
  bit          pend [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];
  logic        p_aid [2];
  int          rr_m, offer, w;
  logic        e_mreq;
  logic [1:0]  e_gnt, e_rv;
  logic [31:0] e_addr, e_wdata;
  logic        e_rid;

  initial begin
    // req, aid, gnt, rvalid, rdata | gnt_o, m_req, m_addr, rvalid_o, rid
    tbl[0]  = '{2'b11, 2'b10, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 32'h1000, 2'b00, 1'b0};
    tbl[1]  = '{2'b11, 2'b10, 1'b1, 1'b1, 32'h11,       2'b10, 1'b1, 32'h2000, 2'b01, 1'b0};
    tbl[2]  = '{2'b11, 2'b10, 1'b1, 1'b1, 32'h22,       2'b01, 1'b1, 32'h1000, 2'b10, 1'b1};
    tbl[3]  = '{2'b11, 2'b10, 1'b1, 1'b1, 32'h33,       2'b10, 1'b1, 32'h2000, 2'b01, 1'b0};
    tbl[4]  = '{2'b00, 2'b10, 1'b0, 1'b1, 32'h44,       2'b00, 1'b0, 32'h0,    2'b10, 1'b1};
    tbl[5]  = '{2'b01, 2'b01, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 32'h1000, 2'b00, 1'b0};
    tbl[6]  = '{2'b00, 2'b01, 1'b0, 1'b1, 32'h55,       2'b00, 1'b0, 32'h0,    2'b01, 1'b1};
    tbl[7]  = '{2'b10, 2'b10, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, 32'h2000, 2'b00, 1'b0};
    tbl[8]  = '{2'b00, 2'b10, 1'b0, 1'b1, 32'h66,       2'b00, 1'b0, 32'h0,    2'b10, 1'b1};
    tbl[9]  = '{2'b10, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b1, 32'h2000, 2'b00, 1'b0};
    tbl[10] = '{2'b11, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b1, 32'h2000, 2'b00, 1'b0};
    tbl[11] = '{2'b11, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b1, 32'h2000, 2'b00, 1'b0};
    tbl[12] = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, 32'h2000, 2'b00, 1'b0};
    tbl[13] = '{2'b01, 2'b00, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 32'h1000, 2'b00, 1'b0};
    tbl[14] = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0,    2'b00, 1'b0};
    tbl[15] = '{2'b11, 2'b00, 1'b1, 1'b1, 32'h77,       2'b00, 1'b0, 32'h0,    2'b10, 1'b0};
    tbl[16] = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, 32'h2000, 2'b00, 1'b0};
    tbl[17] = '{2'b00, 2'b00, 1'b0, 1'b1, 32'h88,       2'b00, 1'b0, 32'h0,    2'b01, 1'b0};
    tbl[18] = '{2'b00, 2'b00, 1'b0, 1'b1, 32'h99,       2'b00, 1'b0, 32'h0,    2'b10, 1'b0};
    tbl[19] = '{2'b01, 2'b00, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 32'h1000, 2'b00, 1'b0};
    tbl[20] = '{2'b10, 2'b10, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, 32'h2000, 2'b00, 1'b0};
    tbl[21] = '{2'b00, 2'b00, 1'b0, 1'b1, 32'hA5A5A5A5, 2'b00, 1'b0, 32'h0,    2'b01, 1'b0};
    tbl[22] = '{2'b00, 2'b00, 1'b0, 1'b1, 32'h5A5A5A5A, 2'b00, 1'b0, 32'h0,    2'b10, 1'b1};

    addr  = {32'h2000, 32'h1000};
    wdata = {32'hBBBB0002, 32'hAAAA0001};
    we    = 2'b01;
    be    = 8'hF3;
    aid   = 2'b00;
    rst_n = 1'b0;
    req   = 2'b11;
    m_gnt = 1'b1;
    m_rvalid = 1'b0;
    m_rdata  = '0;

    // Reset holds every output low even with requests and grant present.
    repeat (2) @(posedge clk);
    #1;
    check("reset.gnt", 64'(gnt), 64'(0));
    check("reset.m_req", 64'(m_req), 64'(0));
    check("reset.rvalid", 64'(rvalid), 64'(0));
    check("reset.rid", 64'(rid), 64'(0));
    req = '0; m_gnt = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 23; i++) begin
      req = tbl[i].req; aid = tbl[i].aid; m_gnt = tbl[i].g;
      m_rvalid = tbl[i].rv; m_rdata = tbl[i].rd;
      @(negedge clk);
      check($sformatf("vec%0d.gnt", i), 64'(gnt), 64'(tbl[i].e_gnt));
      check($sformatf("vec%0d.m_req", i), 64'(m_req), 64'(tbl[i].e_mreq));
      check($sformatf("vec%0d.m_addr", i), 64'(m_addr), 64'(tbl[i].e_addr));
      check($sformatf("vec%0d.rvalid", i), 64'(rvalid), 64'(tbl[i].e_rv));
      check($sformatf("vec%0d.rid", i), 64'(rid), 64'(tbl[i].e_rid));
      if (tbl[i].e_rv != 2'b00)
        check($sformatf("vec%0d.rdata", i), 64'(rdata), 64'(tbl[i].rd));
      @(posedge clk); #1;
    end

    // Reset with one transaction outstanding (port0, aid 0) and port1 locked.
    req = 2'b01; aid = 2'b00; m_gnt = 1'b1; m_rvalid = 1'b0;
    @(negedge clk);
    check("rst6.pre_gnt", 64'(gnt), 64'(2'b01));
    @(posedge clk); #1;
    req = 2'b10; m_gnt = 1'b0;
    @(negedge clk);
    check("rst6.lock_mreq", 64'(m_req), 64'(1));
    @(posedge clk); #1;
    req = 2'b11; m_gnt = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst6.async_gnt", 64'(gnt), 64'(0));
    check("rst6.async_mreq", 64'(m_req), 64'(0));
    check("rst6.async_addr", 64'(m_addr), 64'(0));
    m_rvalid = 1'b1;
    #1;
    check("rst6.stale_rvalid", 64'(rvalid), 64'(0));
    check("rst6.stale_rid", 64'(rid), 64'(0));
    @(negedge clk);
    m_rvalid = 1'b0; req = '0; m_gnt = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req = 2'b11; aid = 2'b01; m_gnt = 1'b1;
    @(negedge clk);
    check("rst6.first_gnt", 64'(gnt), 64'(2'b01));
    @(posedge clk); #1;
    req = '0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hC3C3C3C3;
    @(negedge clk);
    check("rst6.post_rvalid", 64'(rvalid), 64'(2'b01));
    check("rst6.post_rid", 64'(rid), 64'(1));
    @(posedge clk); #1;
    m_rvalid = 1'b0;

    // Randomized run against an in-order queue model.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    q.delete();
    rr_m = 0; offer = -1;
    for (int p = 0; p < 2; p++) pend[p] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p]    = 1'b1;
          p_addr[p]  = $urandom;
          p_wdata[p] = $urandom;
          p_aid[p]   = 1'($urandom_range(0, 1));
        end
        req[p] = pend[p];
        aid[p] = p_aid[p];
        addr[p*32 +: 32]  = p_addr[p];
        wdata[p*32 +: 32] = p_wdata[p];
      end
      m_gnt    = ($urandom_range(0, 3) != 0);
      m_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      m_rdata  = $urandom;

      e_mreq = (pend[0] || pend[1]) && (q.size() < 2);
      w = 0;
      if (offer >= 0) w = offer;
      else if (pend[rr_m]) w = rr_m;
      else w = (rr_m + 1) % 2;
      e_gnt = '0; e_addr = '0; e_wdata = '0; e_rv = '0; e_rid = 1'b0;
      if (e_mreq && m_gnt) e_gnt[w] = 1'b1;
      if (e_mreq) begin
        e_addr  = p_addr[w];
        e_wdata = p_wdata[w];
      end
      if (m_rvalid) begin
        e_rv[q[0].idx] = 1'b1;
        e_rid = 1'(q[0].aid);
      end

      @(negedge clk);
      check($sformatf("rnd%0d.gnt", c), 64'(gnt), 64'(e_gnt));
      check($sformatf("rnd%0d.m_req", c), 64'(m_req), 64'(e_mreq));
      check($sformatf("rnd%0d.m_addr", c), 64'(m_addr), 64'(e_addr));
      check($sformatf("rnd%0d.m_wdata", c), 64'(m_wdata), 64'(e_wdata));
      check($sformatf("rnd%0d.rvalid", c), 64'(rvalid), 64'(e_rv));
      check($sformatf("rnd%0d.rid", c), 64'(rid), 64'(e_rid));

      if (m_rvalid) void'(q.pop_front());
      if (e_mreq && m_gnt) begin
        q.push_back('{w, int'(p_aid[w])});
        rr_m    = (w + 1) % 2;
        offer   = -1;
        pend[w] = 1'b0;
      end else if (e_mreq) begin
        offer = w;
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
